wbm_cmd_initiator: RTL and testbench
====================================

WBM_CMD_INITIATOR -- requirements
Module: wbm_cmd_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: number of wait cycles in BUS before the request is abandoned (legal 2..1023).
REQ-002 SHALL have port wb_clk_i, input, 1: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1: the command is valid.
REQ-005 SHALL have port cmd_ready, output, 1: the block accepts a command.
REQ-006 SHALL have ports cmd_we (input, 1), cmd_sel (input, 4), cmd_adr (input, 32), cmd_dat (input, 32): the write flag, byte selects, address and write data.
REQ-007 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): the response handshake.
REQ-008 SHALL have ports rsp_dat (output, 32) and rsp_err (output, 1): the read data and the timeout flag.
REQ-009 SHALL have Wishbone initiator outputs wbm_cyc_o, wbm_stb_o, wbm_we_o (1 each), wbm_sel_o (4), wbm_adr_o (32), wbm_dat_o (32).
REQ-010 SHALL have Wishbone initiator inputs wbm_ack_i (1) and wbm_dat_i (32).
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement the Wishbone classic single-cycle protocol only; no bursts, no pipelining, and only one outstanding request.
REQ-013 SHALL have the states IDLE, BUS and RESP.
REQ-014 cmd_ready SHALL equal (state==IDLE); a command is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-015 On acceptance at edge N, the block SHALL register we/sel/adr/dat onto wbm_*_o, drive wbm_cyc_o=wbm_stb_o=1 from N+1, and enter BUS.
REQ-016 In BUS, the wbm_* outputs SHALL be held stable until ack or timeout.
REQ-017 When wbm_ack_i is sampled high in BUS at edge M:
- cyc/stb SHALL be low from M+1.
- rsp_dat SHALL capture wbm_dat_i on reads and 0 on writes.
- rsp_err SHALL be 0.
- rsp_valid SHALL be 1 from M+1.
- The state SHALL go to RESP.
REQ-018 The wait counter (10 bits) SHALL clear on entering BUS and increment on each BUS cycle without ack.
REQ-019 If the counter equals TIMEOUT-1 and ack is low, the block SHALL drop cyc/stb, set rsp_err=1 and rsp_dat=0, and enter RESP.
REQ-020 An ack in the same cycle as the timeout condition SHALL win, and the response SHALL complete normally.
REQ-021 In RESP, rsp_valid, rsp_dat and rsp_err SHALL be held until rsp_ready is high.
REQ-022 On the RESP handshake edge, rsp_valid SHALL clear and the state SHALL go to IDLE; cmd_ready is high on the next cycle.
REQ-023 wbm_ack_i SHALL be ignored in IDLE and RESP; a late ack after a timeout SHALL produce no second response.
REQ-024 cmd_* inputs SHALL be ignored outside IDLE.
REQ-025 Minimum throughput SHALL be one transaction per 3 cycles, given zero-wait ack and rsp_ready held high.

Reset
REQ-026 While wb_rst_i is high at an edge:
- The state SHALL go to IDLE and the counter to 0.
- All outputs SHALL be 0, except cmd_ready, which SHALL be 1 after reset.
REQ-027 A reset in BUS or RESP SHALL drop cyc/stb at the next edge and discard the pending response; no rsp_valid SHALL be produced.

Structure
REQ-028 The package wbm_pkg SHALL hold the state encoding (IDLE=0, BUS=1, RESP=2), the counter width constant (10) and the default TIMEOUT.
REQ-029 The wait counter SHALL be the single sub-module wbm_timeout_ctr, with clear, enable and expired ports.
REQ-030 All outputs SHALL come directly from flops, with no combinational input-to-output paths, except cmd_ready, which is decoded from the state.

Verification
REQ-031 Read, ack on 3rd BUS cycle, dat_i=0xDEADBEEF, adr=0x3000_0004 -> stb high for 3 cycles; rsp_valid with rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-032 Write sel=0x3, dat=0x1234_5678, zero-wait ack -> wbm_we_o=1, wbm_sel_o=0x3 for 1 cycle; rsp_dat=0, rsp_err=0.
REQ-033 TIMEOUT=8, no ack -> stb high for exactly 8 cycles; rsp_err=1, rsp_dat=0.
REQ-034 TIMEOUT=8, ack on the 8th BUS cycle -> normal response with rsp_err=0; a late ack 2 cycles after a timeout -> no extra rsp_valid.
REQ-035 rsp_ready held low for 5 cycles -> rsp_* stable for those cycles and cmd_ready=0; three back-to-back commands with rsp_ready=1 -> one transaction per 3 cycles.
REQ-036 wb_rst_i pulsed in the 2nd BUS cycle -> cyc/stb=0 next edge; no response; the next command completes normally.

Source files
------------

// File: rtl/wbm_pkg.sv
// wbm_pkg: shared state encoding and counter sizing for the Wishbone command initiator
package wbm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
    localparam int CTR_W = 10;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/wbm_timeout_ctr.sv
// wbm_timeout_ctr: wait-cycle counter that flags the last permitted BUS cycle
module wbm_timeout_ctr
    import wbm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [CTR_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + CTR_W'(1) : cnt_q;
    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
    assign expired_o = cnt_q == CTR_W'(TIMEOUT - 1);
endmodule

// File: rtl/wbm_cmd_initiator.sv
// wbm_cmd_initiator: turns one command into a single classic Wishbone cycle and returns
// its read data, or an error flag when the target never acknowledges
module wbm_cmd_initiator
    import wbm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);
    state_t      state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d, rvld_q, rvld_d, err_q, err_d, busy_q;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    logic        accept, done, expired;

    assign accept = state_q == IDLE && cmd_valid;
    // ack takes priority over an expiry seen in the same cycle
    assign done = state_q == BUS && (wbm_ack_i || expired);

    wbm_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clear_i  (accept),
        .enable_i (state_q == BUS && !wbm_ack_i),
        .expired_o(expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rvld_q  <= rvld_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = BUS;
            BUS:     if (wbm_ack_i || expired) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d  = accept ? 1'b1 : done ? 1'b0 : cyc_q;
        we_d   = accept ? cmd_we : we_q;
        sel_d  = accept ? cmd_sel : sel_q;
        adr_d  = accept ? cmd_adr : adr_q;
        dat_d  = accept ? cmd_dat : dat_q;
        rvld_d = done ? 1'b1 : (state_q == RESP && rsp_ready) ? 1'b0 : rvld_q;
        rdat_d = done ? ((wbm_ack_i && !we_q) ? wbm_dat_i : '0) : rdat_q;
        err_d  = done ? !wbm_ack_i : err_q;
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = busy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rvld_q;
    assign rsp_dat   = rdat_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_wbm_cmd_initiator.sv
// tb_wbm_cmd_initiator: directed and randomized transactions against a timing/response model
module tb_wbm_cmd_initiator;
    localparam int TO = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0, wbm_ack_i = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0, wbm_dat_i = '0;
    logic        cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy;
    logic [3:0]  wbm_sel_o;
    logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o;
    int          n_tests = 0, n_fail = 0;

    wbm_cmd_initiator #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ack_at: BUS cycle (1-based) on which the target acks, 0 = never
    task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [31:0] rdata,
                           input int ack_at, input int rsp_delay, input bit late_ack);
        bit          acked = ack_at > 0 && ack_at <= TO;
        int          exp_cyc = acked ? ack_at : TO;
        logic [31:0] exp_rdat = (acked && !we) ? rdata : 32'h0;
        int          n = 0;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        @(negedge clk);
        while (wbm_stb_o && n < TO + 4) begin
            n++;
            check("bus_adr", wbm_adr_o, adr);
            check("bus_we", wbm_we_o, we);
            check("bus_sel", wbm_sel_o, sel);
            check("bus_dat", wbm_dat_o, dat);
            check("bus_cyc", wbm_cyc_o, 1);
            check("bus_cmd_ready", cmd_ready, 0);
            check("bus_busy", busy, 1);
            check("bus_rsp_valid", rsp_valid, 0);
            cmd_valid = 1'($urandom); cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
            cmd_adr = $urandom; cmd_dat = $urandom;
            wbm_ack_i = n == ack_at;
            wbm_dat_i = (n == ack_at) ? rdata : $urandom;
            @(negedge clk);
        end
        wbm_ack_i = 0; cmd_valid = 0;
        check("stb_cycles", n, exp_cyc);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, !acked);
        check("rsp_dat", rsp_dat, exp_rdat);
        check("cyc_after", wbm_cyc_o, 0);
        check("resp_busy", busy, 1);
        for (int i = 0; i < rsp_delay; i++) begin
            rsp_ready = 0;
            wbm_ack_i = late_ack && i == 1;
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_dat", rsp_dat, exp_rdat);
            check("hold_err", rsp_err, !acked);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        wbm_ack_i = 0; rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("hs_valid", rsp_valid, 0);
        check("hs_cmd_ready", cmd_ready, 1);
        check("hs_busy", busy, 0);
        if (late_ack) begin
            wbm_ack_i = 1;
            @(negedge clk);
            wbm_ack_i = 0;
            check("late_ack_valid", rsp_valid, 0);
            check("late_ack_busy", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];
        int accepts = 0, resps = 0;
        repeat (3) @(negedge clk);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_we", wbm_we_o, 0);
        check("rst_sel", wbm_sel_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 0;
        @(negedge clk);

        run_txn(0, 4'hF, 32'h3000_0004, 32'h0, 32'hDEAD_BEEF, 3, 0, 0);
        run_txn(1, 4'h3, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_F00D, 1, 0, 0);
        run_txn(0, 4'hF, 32'h0000_0200, 32'h0, 32'h1111_2222, 0, 1, 0);
        run_txn(0, 4'hF, 32'h0000_0300, 32'h0, 32'h3333_4444, 8, 0, 0);
        run_txn(0, 4'hF, 32'h0000_0400, 32'h0, 32'h5555_6666, 9, 5, 1);
        run_txn(0, 4'h1, 32'h0000_0500, 32'h0, 32'h7777_8888, 2, 5, 0);

        // back-to-back zero-wait commands with rsp_ready held high
        rsp_ready = 1; cmd_valid = 1; cmd_we = 0; cmd_sel = 4'hF; cmd_adr = $urandom;
        for (int c = 0; c < 9; c++) begin
            if (rsp_valid) begin
                resps++;
                if (exp_q.size() == 0) check("b2b_extra_rsp", 1, 0);
                else check("b2b_rsp_dat", rsp_dat, exp_q.pop_front());
            end
            wbm_ack_i = wbm_stb_o;
            wbm_dat_i = wbm_adr_o ^ 32'hA5A5_0000;
            if (cmd_ready) begin
                accepts++;
                exp_q.push_back(cmd_adr ^ 32'hA5A5_0000);
            end
            @(negedge clk);
            if (cmd_ready) cmd_adr = $urandom;
        end
        cmd_valid = 0; wbm_ack_i = 0; rsp_ready = 0;
        check("b2b_accepts", accepts, 3);
        check("b2b_resps", resps, 3);
        check("b2b_pending", exp_q.size(), 0);
        @(negedge clk);

        // reset in the second BUS cycle discards the transaction
        cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h0000_0600;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_cyc", wbm_cyc_o, 0);
        check("midrst_stb", wbm_stb_o, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            wbm_ack_i = 1'($urandom);
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 0);
        end
        wbm_ack_i = 0;
        run_txn(0, 4'hF, 32'h0000_0700, 32'h0, 32'h9999_AAAA, 2, 0, 0);

        for (int t = 0; t < 20; t++)
            run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, TO + 2), $urandom_range(0, 4), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
